// File: rtl/ai_accel_wb_initiator.sv
// Wishbone initiator that runs one matmul job on the accelerator responder.
// Optional per-strobe watchdog: define WB_TIMEOUT_EN.
module ai_accel_wb_initiator #(
    parameter int IDX_W       = 15,
    parameter int MAX_DIM     = 15,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        wishbone_clk_i,
    input  logic        wishbone_rst_ni,
    input  logic        job_start_i,
    input  logic [4:0]  job_rows_a_i,
    input  logic [4:0]  job_cols_a_i,
    input  logic [4:0]  job_cols_b_i,
    output logic        job_busy_o,
    output logic        job_done_o,
    output logic        job_err_o,
    input  logic        in_valid_i,
    input  logic [31:0] in_data_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    output logic        out_last_o,
    input  logic        out_ready_i,
    output logic [31:0] wishbone_addr_o,
    output logic        wishbone_we_o,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_stb_o,
    input  logic        wishbone_ack_i,
    input  logic [31:0] wishbone_data_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_LOAD_A, S_LOAD_B, S_GO, S_WAIT, S_READ, S_PUSH, S_DONE, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         rows_a_q, rows_a_d, cols_a_q, cols_a_d, cols_b_q, cols_b_d;
    logic [IDX_W-1:0]   row_q, row_d, col_q, col_d;
    logic [2:0]         cfg_idx_q, cfg_idx_d;
    logic               stb_q, stb_d, we_q, we_d;
    logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

    logic [4:0]         row_lim, col_lim;
    logic [IDX_W-1:0]   row_max, col_max;
    logic               last_elem, ack_v, dims_ok;
    logic [31:0]        cfg_val;

`ifdef WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    function automatic logic dim_ok(input logic [4:0] d);
        return (d != 5'd0) && (int'(d) <= MAX_DIM);
    endfunction

    // The same row/col counters walk A, B and C; only the limits change.
    always_comb begin
        case (state_q)
            S_LOAD_A: begin row_lim = rows_a_q; col_lim = cols_a_q; end
            S_LOAD_B: begin row_lim = cols_a_q; col_lim = cols_b_q; end
            default:  begin row_lim = rows_a_q; col_lim = cols_b_q; end
        endcase
    end

    assign row_max   = IDX_W'(row_lim - 5'd1);
    assign col_max   = IDX_W'(col_lim - 5'd1);
    assign last_elem = (row_q == row_max) && (col_q == col_max);
    assign ack_v     = stb_q & wishbone_ack_i;
    assign dims_ok   = dim_ok(job_rows_a_i) && dim_ok(job_cols_a_i) && dim_ok(job_cols_b_i);

    always_comb begin
        case (cfg_idx_q)
            3'd0:    cfg_val = 32'd1;
            3'd1:    cfg_val = 32'(cols_a_q);
            3'd2:    cfg_val = 32'(rows_a_q);
            3'd3:    cfg_val = 32'(cols_b_q);
            default: cfg_val = 32'(cols_a_q);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rows_a_d  = rows_a_q;
        cols_a_d  = cols_a_q;
        cols_b_d  = cols_b_q;
        row_d     = row_q;
        col_d     = col_q;
        cfg_idx_d = cfg_idx_q;
        stb_d     = stb_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;

        case (state_q)
            S_IDLE: if (job_start_i) begin
                if (dims_ok) begin
                    state_d   = S_CFG;
                    rows_a_d  = job_rows_a_i;
                    cols_a_d  = job_cols_a_i;
                    cols_b_d  = job_cols_b_i;
                    row_d     = '0;
                    col_d     = '0;
                    cfg_idx_d = '0;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_CFG: begin
                if (!stb_q) begin
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = 32'(cfg_idx_q);
                    wdata_d = cfg_val;
                end else if (ack_v) begin
                    stb_d = 1'b0;
                    if (cfg_idx_q == 3'd4) state_d = S_LOAD_A;
                    else cfg_idx_d = cfg_idx_q + 3'd1;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                in_ready_o = !stb_q;
                if (!stb_q && in_valid_i) begin
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = 32'({(state_q == S_LOAD_A) ? 2'b01 : 2'b10, row_q, col_q});
                    wdata_d = in_data_i;
                end else if (ack_v) begin
                    stb_d = 1'b0;
                    if (last_elem) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_GO;
                    end else if (col_q == col_max) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_GO: begin
                if (!stb_q) begin
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = 32'd5;
                    wdata_d = 32'hFFFF_FFFF;
                end else if (ack_v) begin
                    stb_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            // WAIT is the first C read at (0,0); the responder stalls its ack until done.
            S_WAIT, S_READ: begin
                if (!stb_q) begin
                    stb_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = 32'({2'b00, row_q, col_q});
                end else if (ack_v) begin
                    stb_d   = 1'b0;
                    rdata_d = wishbone_data_i;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (last_elem) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                        if (col_q == col_max) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE, S_ERR: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase

`ifdef WB_TIMEOUT_EN
        tmo_d = (!stb_q || wishbone_ack_i) ? '0 : tmo_q + 1'b1;
        if (stb_q && !wishbone_ack_i && (tmo_q == TW'(TIMEOUT_CYC - 1))) begin
            stb_d   = 1'b0;
            state_d = S_ERR;
        end
`endif
    end

    always_ff @(posedge wishbone_clk_i or negedge wishbone_rst_ni) begin
        if (!wishbone_rst_ni) begin
            state_q   <= S_IDLE;
            rows_a_q  <= '0;
            cols_a_q  <= '0;
            cols_b_q  <= '0;
            row_q     <= '0;
            col_q     <= '0;
            cfg_idx_q <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
`ifdef WB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rows_a_q  <= rows_a_d;
            cols_a_q  <= cols_a_d;
            cols_b_q  <= cols_b_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cfg_idx_q <= cfg_idx_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
`ifdef WB_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign job_busy_o      = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    assign job_done_o      = (state_q == S_DONE);
    assign job_err_o       = (state_q == S_ERR);
    assign out_data_o      = rdata_q;
    assign out_last_o      = (state_q == S_PUSH) && last_elem;
    assign wishbone_addr_o = addr_q;
    assign wishbone_we_o   = we_q;
    assign wishbone_data_o = wdata_q;
    assign wishbone_stb_o  = stb_q;

endmodule
